// File: rtl/multdiv_seq.sv
// Sequential signed multiplier / divider: one radix-2 step per cycle on operand magnitudes,
// with the sign and the overflow/divide-by-zero flag resolved when the last step completes.
module multdiv_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam logic [PW-1:0] MIN_MAG = PW'(1) << (WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] hi, lo, a_mag, b_mag;
   logic             neg;

   logic             start_c, both_c, iter_c, last_c;
   logic [WIDTH:0]   mult_sum_c, div_shift_c;
   logic             div_ge_c;
   logic [WIDTH-1:0] div_rem_c, signed_res_c;
   logic [PW-1:0]    prod_mag_c;
   logic             mult_ovf_c, div_ovf_c;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? -x : x;
   endfunction

   assign start_c = ctrl_MULT | ctrl_DIV;
   assign both_c  = ctrl_MULT & ctrl_DIV;
   assign iter_c  = (state == MULT) || (state == DIV);
   assign last_c  = iter_c && (cnt == CNT_W'(WIDTH));

   // Shift-add step: hi accumulates, lo holds the multiplier and collects product low bits
   assign mult_sum_c  = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);

   // Restoring step: hi is the partial remainder, lo shifts the dividend out and quotient in
   assign div_shift_c = {hi, lo[WIDTH-1]};
   assign div_ge_c    = div_shift_c >= {1'b0, b_mag};
   assign div_rem_c   = div_ge_c ? WIDTH'(div_shift_c - {1'b0, b_mag}) : WIDTH'(div_shift_c);

   // Low half of a negated product depends only on the low half, so both ops share this
   assign signed_res_c = neg ? -lo : lo;
   assign prod_mag_c   = {hi, lo};
   assign mult_ovf_c   = neg ? (prod_mag_c > MIN_MAG) : (prod_mag_c >= MIN_MAG);
   assign div_ovf_c    = !neg && lo[WIDTH-1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (both_c)         state_nxt = DONE;
      else if (ctrl_MULT) state_nxt = MULT;
      else if (ctrl_DIV)  state_nxt = DIV;
      else begin
         case (state)
            MULT, DIV: if (last_c) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt            <= '0;
         hi             <= '0;
         lo             <= '0;
         a_mag          <= '0;
         b_mag          <= '0;
         neg            <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         busy           <= (state_nxt == MULT) || (state_nxt == DIV);
         if (start_c) begin
            a_mag <= mag(data_operandA);
            b_mag <= mag(data_operandB);
            neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            cnt   <= '0;
            hi    <= '0;
            lo    <= ctrl_MULT ? mag(data_operandB) : mag(data_operandA);
            if (both_c) begin
               data_result    <= '0;
               data_exception <= 1'b1;
               data_resultRDY <= 1'b1;
            end
         end else if (last_c) begin
            data_resultRDY <= 1'b1;
            if (state == MULT) begin
               data_result    <= signed_res_c;
               data_exception <= mult_ovf_c;
            end else if (b_mag == '0) begin
               data_result    <= '0;
               data_exception <= 1'b1;
            end else begin
               data_result    <= signed_res_c;
               data_exception <= div_ovf_c;
            end
         end else if (iter_c) begin
            cnt <= cnt + CNT_W'(1);
            if (state == MULT) begin
               {hi, lo} <= {mult_sum_c, lo[WIDTH-1:1]};
            end else begin
               hi <= div_rem_c;
               lo <= {lo[WIDTH-2:0], div_ge_c};
            end
         end
      end
   end

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: the driver queues hand-computed results with their
// expected RDY cycle, and a monitor checks every RDY pulse against the queue head.
module tb_multdiv_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] data_operandA, data_operandB;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY, busy;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        exc;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   multdiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Drives a one-cycle start; RDY must appear after the 33rd edge following the start edge
   task automatic issue(input string name, input bit m, input bit d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic exc, input bit push);
      exp_t e;
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      e.name = name;
      e.res  = res;
      e.exc  = exc;
      e.cyc  = (m && d) ? cyc + 1 : cyc + 34;
      if (push) exp_q.push_back(e);
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = 32'hDEAD_BEEF;
      data_operandB = 32'h0000_0000;
      if (!(m && d)) check({name, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic run(input string name, input bit m, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] res, input logic exc);
      issue(name, m, !m, a, b, res, exc, 1'b1);
      repeat (32) @(negedge clock);
   endtask

   // Monitor: every RDY pulse must match the queue head in value and timing
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset && data_resultRDY) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rdy", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check({e.name, "_res"}, data_result, e.res);
               check({e.name, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
               check({e.name, "_cyc"}, cyc, e.cyc);
               check({e.name, "_busy_done"}, {31'd0, busy}, 32'd0);
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (2) @(negedge clock);
      check("rst_res",  data_result, 32'd0);
      check("rst_exc",  {31'd0, data_exception}, 32'd0);
      check("rst_rdy",  {31'd0, data_resultRDY}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;

      run("mul_7_m3",     1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      run("mul_ovf_2p32", 1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
      run("div_m7_2",     1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
      run("div_5_0",      1'b0, 32'd5,          32'd0,         32'h0000_0000, 1'b1);
      run("mul_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run("mul_min_1",    1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
      run("mul_m65536_32768", 1'b1, 32'hFFFF_0000, 32'd32768,  32'h8000_0000, 1'b0);
      run("mul_max_1",    1'b1, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0);
      run("mul_ffff_sq",  1'b1, 32'h0000_FFFF,  32'h0000_FFFF, 32'hFFFE_0001, 1'b1);
      run("mul_m4_m5",    1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFB, 32'd20,        1'b0);
      run("div_min_m1",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run("div_m100_m7",  1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        1'b0);
      run("div_7_m100",   1'b0, 32'd7,          32'hFFFF_FF9C, 32'd0,         1'b0);

      // Abort: a DIV started mid-MULT replaces it; only the DIV result appears
      issue("abort_mul", 1'b1, 1'b0, 32'd3, 32'd3, 32'd9, 1'b0, 1'b0);
      repeat (8) @(negedge clock);
      issue("div_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
      repeat (34) @(negedge clock);

      issue("both", 1'b1, 1'b1, 32'd6, 32'd2, 32'd0, 1'b1, 1'b1);
      repeat (3) @(negedge clock);
      check("hold_res", data_result, 32'd0);
      check("hold_exc", {31'd0, data_exception}, 32'd1);

      // Reset in the middle of a MULT discards it immediately
      issue("rst_mul", 1'b1, 1'b0, 32'd11, 32'd13, 32'd143, 1'b0, 1'b0);
      repeat (13) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_res",  data_result, 32'd0);
      check("midrst_exc",  {31'd0, data_exception}, 32'd0);
      check("midrst_rdy",  {31'd0, data_resultRDY}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (40) @(negedge clock);

      run("post_rst_mul", 1'b1, 32'd12, 32'd12, 32'd144, 1'b0);

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
- REQ-001: Parameter WIDTH, default 32, operand and result width; only 32 is required to work.
- REQ-002: Parameter CNT_W, default 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.
- REQ-003: clock  input  1  single clock; all state changes on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: data_operandA  input  32  multiplicand / dividend, two's complement.
- REQ-006: data_operandB  input  32  multiplier / divisor, two's complement.
- REQ-007: ctrl_MULT  input  1  single-cycle start pulse for a multiply.
- REQ-008: ctrl_DIV  input  1  single-cycle start pulse for a divide.
- REQ-009: data_result  output  32  registered result.
- REQ-010: data_exception  output  1  registered overflow / divide-by-zero flag.
- REQ-011: data_resultRDY  output  1  one-cycle pulse when the result is valid.
- REQ-012: busy  output  1  high while an operation is iterating.

Function
- REQ-013: The FSM SHALL have exactly four states: IDLE, MULT, DIV and DONE.
- REQ-014: A start SHALL be the sampling of ctrl_MULT or ctrl_DIV high on a rising edge, in any state.
  - At that edge, data_operandA and data_operandB SHALL be latched.
  - At that edge, the internal CNT_W-bit iteration counter SHALL clear to 0.
  - At that edge, the FSM SHALL enter MULT or DIV.
- REQ-015: ctrl_MULT and ctrl_DIV sampled high on the same edge SHALL cause the following:
  - Transition to DONE on that edge.
  - data_result=0 and data_exception=1 when RDY pulses.
- REQ-016: A start while in MULT or DIV SHALL abort the current operation without an RDY pulse and restart with the new operands.
- REQ-017: MULT and DIV SHALL each perform one radix-2 iteration per cycle on operand magnitudes, 32 iterations, counter incrementing 0..32.
  - Multiply uses unsigned shift-add.
  - Divide uses restoring division.
- REQ-018: When the counter reaches 32, the FSM SHALL go to DONE.
  - The sign SHALL be applied: negate if exactly one operand is negative.
  - data_result and data_exception SHALL load on that same edge.
- REQ-019: Latency: data_resultRDY SHALL be high in exactly the cycle following the 33rd rising edge after the start edge, and low otherwise.
- REQ-020: DONE SHALL last one cycle, then go to IDLE unless a start is sampled, in which case REQ-014 applies.
- REQ-021: busy SHALL be 1 in MULT and DIV, and 0 in IDLE and DONE.
- REQ-022: Multiply result and exception:
  - data_result SHALL be the low 32 bits of the signed 64-bit product.
  - data_exception=1 iff the product lies outside [-2^31, 2^31-1], e.g. 0x80000000 * -1.
- REQ-023: Divide result SHALL be the quotient truncated toward zero; the remainder is discarded.
- REQ-024: Divisor 0 SHALL give data_result=0 and data_exception=1, with unchanged latency.
- REQ-025: 0x80000000 / -1 SHALL give data_result=0x80000000 and data_exception=1.
- REQ-026: data_result and data_exception SHALL hold their last value until the next DONE entry.
- REQ-027: Operand inputs SHALL be ignored except at a start edge.

Reset
- REQ-028: While reset=0 all of the following SHALL hold, immediately and independent of clock:
  - State is IDLE and the counter is 0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- REQ-029: Reset asserted mid-operation SHALL discard that operation; no RDY pulse SHALL follow.
- REQ-030: The first rising edge after reset releases SHALL accept a start normally.

Verification
- REQ-031: MULT 7 x -3 -> data_result=0xFFFFFFEB, exception=0, RDY single pulse in the cycle following the 33rd rising edge after the start edge.
- REQ-032: MULT 0x00010000 x 0x00010000 -> data_result=0x00000000, exception=1.
- REQ-033: DIV -7 / 2 -> data_result=0xFFFFFFFD, exception=0; DIV 5 / 0 -> data_result=0, exception=1.
- REQ-034: MULT start, then DIV 100 / 7 started 10 cycles later -> exactly one RDY pulse, in the cycle following the 33rd rising edge after the DIV start edge, data_result=14.
- REQ-035: ctrl_MULT and ctrl_DIV high together -> RDY next cycle, data_result=0, exception=1.
- REQ-036: reset=0 at cycle 15 of a MULT -> busy=0 and outputs 0 immediately; no RDY within 40 cycles after release.
